// File: rtl/fpmul_sequencer.sv
// fpmul_sequencer
//   Operand sequencer in front of the serial-operand fpmultiplier. Operand
//   pairs arrive on a valid/ready stream and are queued. Each pair is driven
//   onto the multiplier's single `a` bus on two back-to-back cycles (A, then B).
//   The sequencer then waits for a rising edge on the multiplier's `ready`.
//   The product is returned on a valid/ready stream. If the multiplier hangs,
//   a watchdog reports a qNaN flagged as a timeout and pulses the multiplier's
//   reset.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   in_valid/in_ready         operand pair stream, in_a / in_b (IEEE single bits)
//   out_valid/out_ready       result stream, out_product, out_timeout
//   mul_a                     serial operand bus to the multiplier
//   mul_nreset                active-low reset to the multiplier
//   mul_product, mul_ready    multiplier result and completion flag
//
// FIFO_DEPTH must be a power of two, at least 2.

module fpmul_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int RST_PULSE  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        out_timeout,
    output logic [31:0] mul_a,
    output logic        mul_nreset,
    input  logic [31:0] mul_product,
    input  logic        mul_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(RST_PULSE + 1);

    localparam logic [AW:0]   PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_ONE = 1;
    localparam logic [PW-1:0] PULSE_TO  = PW'(RST_PULSE);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_ISSUE_A = 3'd2;
    localparam logic [2:0] ST_ISSUE_B = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;

    logic [2:0]    state;
    logic          ready_q;
    logic          rise;
    logic [CW-1:0] wait_cnt;
    logic [PW-1:0] pulse_cnt;
    logic [31:0]   op_a;
    logic [31:0]   op_b;

    logic [31:0]   fifo_a [FIFO_DEPTH];
    logic [31:0]   fifo_b [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          expire;

    assign rise  = mul_ready && !ready_q;

    // The extra pointer MSB tells full (MSBs differ) from empty (all equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // in_ready follows occupancy only. A pop in the same cycle does not free
    // a slot until the next cycle.
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // An unaccepted result blocks the next issue.
    assign pop      = (state == ST_IDLE) && !empty && !out_valid;

    // A rise on the expiry cycle wins over the timeout.
    assign expire   = (state == ST_WAIT) && !rise && (wait_cnt == CNT_LAST);

    // Low combinationally while reset is asserted. The registered counter
    // then keeps it low for the following cycle.
    assign mul_nreset = !reset && (pulse_cnt == '0);

    // B stays on the bus throughout WAIT.
    always_comb begin
        mul_a = '0;
        case (state)
            ST_ISSUE_A:          mul_a = op_a;
            ST_ISSUE_B, ST_WAIT: mul_a = op_b;
            default:             mul_a = '0;
        endcase
    end

    // Data storage has no reset. Validity is carried by the pointers and FSM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a[wr_ptr[AW-1:0]] <= in_a;
            fifo_b[wr_ptr[AW-1:0]] <= in_b;
        end
        if (pop) begin
            op_a <= fifo_a[rd_ptr[AW-1:0]];
            op_b <= fifo_b[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_INIT;
            ready_q     <= 1'b0;
            wait_cnt    <= '0;
            pulse_cnt   <= PULSE_ONE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_timeout <= 1'b0;
        end else begin
            ready_q <= mul_ready;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (pulse_cnt != '0)
                pulse_cnt <= pulse_cnt - PULSE_ONE;

            // Clear on acceptance. A load in WAIT below overrides this.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                ST_INIT: begin
                    if (rise)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pop)
                        state <= ST_ISSUE_A;
                end
                ST_ISSUE_A: begin
                    state <= ST_ISSUE_B;
                end
                ST_ISSUE_B: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rise) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (expire) begin
                        out_product <= QNAN;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        pulse_cnt   <= PULSE_TO;
                        state       <= ST_INIT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_sequencer.sv
// tb_fpmul_sequencer
//   Self-checking bench for fpmul_sequencer (default parameters).
//   - Directed table: operand pairs with a multiplier response and the
//     expected product.
//   - Hand-written sequences: timeout, reset in WAIT, FIFO fill, backpressure.
//   - Randomized traffic: a behavioural multiplier plus a result scoreboard.

module tb_fpmul_sequencer;

    localparam int TIMEOUT = 64;
    localparam int NR      = 40;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_timeout;
    logic [31:0] mul_a;
    logic        mul_nreset;
    logic [31:0] mul_product;
    logic        mul_ready;

    fpmul_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_timeout (out_timeout),
        .mul_a       (mul_a),
        .mul_nreset  (mul_nreset),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] mprod;
        logic [31:0] exp_prod;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Behavioural multiplier and scoreboard state.
    bit          auto_on = 0;
    pair_t       pend_q[$];
    logic [31:0] res_q[$];
    int          mm      = 0;
    int          lcnt    = 0;
    int          got     = 0;
    int          pushed  = 0;
    bit          hold_vld = 0;
    logic [31:0] hold_p  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Multiplier model, run once per cycle after the edge. It watches for A
    // then B on the bus, waits a random latency, then pulses ready for one
    // cycle with a random product that the scoreboard expects back.
    task automatic mul_step();
        logic [31:0] p;
        case (mm)
            0: if (mul_a != 32'h0) begin
                if (pend_q.size() == 0) begin
                    chk("mdl_issue_unexpected", mul_a, 32'h0);
                end else begin
                    chk("mdl_issue_a", mul_a, pend_q[0].a);
                    mm = 1;
                end
            end
            1: begin
                chk("mdl_issue_b", mul_a, pend_q[0].b);
                lcnt = $urandom_range(0, 6);
                mm = 2;
            end
            2: if (lcnt == 0) begin
                p = $urandom;
                mul_product = p;
                mul_ready = 1'b1;
                res_q.push_back(p);
                void'(pend_q.pop_front());
                mm = 3;
            end else begin
                lcnt--;
            end
            default: begin
                mul_ready = 1'b0;
                mm = 0;
            end
        endcase
    endtask

    // One clock. Handshakes are observed just before the edge that completes
    // them. Outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        if (auto_on) begin
            if (in_valid && in_ready) begin
                pend_q.push_back({in_a, in_b});
                pushed++;
            end
            if (hold_vld)
                chk("out_stable", out_product, hold_p);
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got %h with no result expected", out_product);
                end else begin
                    chk("out_product", out_product, res_q.pop_front());
                    chk("out_timeout", {31'b0, out_timeout}, 32'h0);
                end
                got++;
            end
            hold_vld = out_valid && !out_ready;
            hold_p   = out_product;
        end
        @(posedge clock);
        #1;
        if (auto_on) mul_step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend_q.delete();
        res_q.delete();
        mm = 0; got = 0; pushed = 0; hold_vld = 0;
        mul_ready = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic init_rise();
        mul_ready = 1'b1;
        cyc();
        mul_ready = 1'b0;
    endtask

    // Directed pair with a hand-driven multiplier. Starts and ends in IDLE.
    task automatic run_pair(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input logic [31:0] mprod, input logic [31:0] eprod);
        in_valid = 1'b1; in_a = a; in_b = b;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk({nm, "_issue_a"}, mul_a, a);
        cyc();
        chk({nm, "_issue_b"}, mul_a, b);
        cyc();
        chk({nm, "_wait_hold"}, mul_a, b);
        for (int k = 0; k < lat; k++) begin
            chk({nm, "_no_early_valid"}, {31'b0, out_valid}, 32'h0);
            cyc();
        end
        mul_ready = 1'b1; mul_product = mprod;
        cyc();
        mul_ready = 1'b0;
        chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'h1);
        chk({nm, "_out_product"}, out_product, eprod);
        chk({nm, "_out_timeout"}, {31'b0, out_timeout}, 32'h0);
        chk({nm, "_idle_bus"}, mul_a, 32'h0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({nm, "_accepted"}, {31'b0, out_valid}, 32'h0);
    endtask

    task automatic drain(input string nm, input int target);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (got < target && guard < 500) begin
            cyc();
            guard++;
        end
        chk({nm, "_results"}, 32'(got), 32'(target));
    endtask

    initial begin
        vec_t        vecs[5];
        pair_t       fp[5];
        pair_t       bp0, bp1;
        logic [31:0] held;
        int          n, guard, base;

        vecs[0] = '{a:32'hBFC00000, b:32'h3FE00000, lat:3, mprod:32'hC0280000, exp_prod:32'hC0280000};
        vecs[1] = '{a:32'h7F800000, b:32'h00000000, lat:1, mprod:32'h7FC00000, exp_prod:32'h7FC00000};
        vecs[2] = '{a:32'h00068868, b:32'h80000000, lat:2, mprod:32'h80000000, exp_prod:32'h80000000};
        vecs[3] = '{a:32'hFF800000, b:32'h7F800000, lat:0, mprod:32'hFF800000, exp_prod:32'hFF800000};
        vecs[4] = '{a:32'h7FC00001, b:32'h3F800000, lat:5, mprod:32'h7FC00001, exp_prod:32'h7FC00001};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; mul_product = '0; mul_ready = 1'b0;

        // Reset state.
        cyc();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_product", out_product, 32'h0);
        chk("rst_out_timeout", {31'b0, out_timeout}, 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_nreset_during", {31'b0, mul_nreset}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_nreset_after", {31'b0, mul_nreset}, 32'h0);
        cyc();
        chk("rst_nreset_release", {31'b0, mul_nreset}, 32'h1);
        init_rise();

        // Directed table.
        for (int i = 0; i < 5; i++)
            run_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lat,
                     vecs[i].mprod, vecs[i].exp_prod);

        // Timeout. The multiplier never answers. Counting starts from the
        // ISSUE_B cycle, so out_valid shows after TIMEOUT cycles of WAIT.
        in_valid = 1'b1; in_a = 32'h40490FDB; in_b = 32'h402DF854;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("to_issue_b", mul_a, 32'h402DF854);
        n = 0;
        while (!out_valid && n < 200) begin
            cyc();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("to_product", out_product, 32'h7FC00000);
        chk("to_flag", {31'b0, out_timeout}, 32'h1);
        chk("to_nreset_1", {31'b0, mul_nreset}, 32'h0);
        chk("to_init_bus", mul_a, 32'h0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("to_nreset_2", {31'b0, mul_nreset}, 32'h0);
        chk("to_accepted", {31'b0, out_valid}, 32'h0);
        cyc();
        chk("to_nreset_release", {31'b0, mul_nreset}, 32'h1);
        init_rise();
        run_pair("to_next", 32'h3F800000, 32'h40000000, 2, 32'h40000000, 32'h40000000);

        // Reset while in WAIT with three pairs queued behind the one in flight.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 32'h1000 + i; in_b = 32'h2000 + i;
            cyc();
        end
        in_valid = 1'b0;
        chk("rw_not_full", {31'b0, in_ready}, 32'h1);
        cyc();
        reset = 1'b1;
        #1;
        chk("rw_nreset_during", {31'b0, mul_nreset}, 32'h0);
        cyc();
        reset = 1'b0;
        #1;
        chk("rw_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rw_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rw_nreset_after", {31'b0, mul_nreset}, 32'h0);
        cyc();
        chk("rw_nreset_release", {31'b0, mul_nreset}, 32'h1);
        mul_product = 32'hDEADBEEF;
        init_rise();
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rw_no_stale_valid", {31'b0, out_valid}, 32'h0);
            chk("rw_fifo_empty_bus", mul_a, 32'h0);
        end

        // FIFO fill while still in INIT. The multiplier is busy and has not
        // signalled ready yet.
        auto_on = 1;
        do_reset();
        for (int i = 0; i < 5; i++) fp[i] = {($urandom | 32'h1), $urandom};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = fp[i].a; in_b = fp[i].b;
            cyc();
        end
        chk("fill_full", {31'b0, in_ready}, 32'h0);
        in_a = fp[4].a; in_b = fp[4].b;
        for (int k = 0; k < 3; k++) cyc();
        chk("fill_still_full", {31'b0, in_ready}, 32'h0);
        init_rise();
        chk("fill_full_on_pop_cycle", {31'b0, in_ready}, 32'h0);
        cyc();
        chk("fill_slot_freed", {31'b0, in_ready}, 32'h1);
        chk("fill_first_issue", mul_a, fp[0].a);
        cyc();
        in_valid = 1'b0;
        chk("fill_pushed", 32'(pushed), 32'd5);
        drain("fill", 5);

        // Backpressure: one result held while the second pair waits in IDLE.
        out_ready = 1'b0;
        base = got;
        bp0 = {($urandom | 32'h1), $urandom};
        bp1 = {($urandom | 32'h1), $urandom};
        in_valid = 1'b1; in_a = bp0.a; in_b = bp0.b;
        cyc();
        in_a = bp1.a; in_b = bp1.b;
        cyc();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            cyc();
            guard++;
        end
        chk("bp_first_valid", {31'b0, out_valid}, 32'h1);
        held = out_product;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("bp_held_valid", {31'b0, out_valid}, 32'h1);
            chk("bp_held_product", out_product, held);
            chk("bp_idle_bus", mul_a, 32'h0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_accepted", {31'b0, out_valid}, 32'h0);
        chk("bp_pop_cycle_bus", mul_a, 32'h0);
        cyc();
        chk("bp_second_issue", mul_a, bp1.a);
        drain("bp", base + 2);

        // Randomized traffic against the multiplier model and scoreboard.
        base = got; pushed = 0; guard = 0;
        while ((got - base) < NR && guard < 6000) begin
            if (pushed < NR) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = $urandom | 32'h1;
                in_b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_results", 32'(got - base), 32'(NR));
        chk("rand_scoreboard_empty", 32'(res_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
